// File: rtl/fifo_drain.sv
// fifo_drain: read-side master for the FIFO.
// It pops words through the FIFO's read_request/empty/data_out interface.
// It presents them downstream as a valid/ready stream.
// A prefetch buffer of READ_LATENCY+1 entries hides the FIFO read latency.
// With that buffer, a sink that stays ready receives one word per cycle.
//
// Ports:
//   i_clk               rising-edge clock
//   i_reset             synchronous active-high reset
//   i_enable            1 = fetch from the FIFO, 0 = stop reading and drain
//   i_fifo_empty        FIFO empty flag
//   i_fifo_data         FIFO data_out
//   o_fifo_read_request pop strobe to the FIFO, one word per asserted cycle
//   o_out_valid         o_out_data holds a word
//   i_out_ready         sink accepts the word this cycle
//   o_out_data          head word of the prefetch buffer
//   o_busy              FSM is not IDLE
//   o_xfer_count        words accepted downstream, wraps modulo 2^COUNT_WIDTH
module fifo_drain #(
  parameter int WIDTH        = 4,
  parameter int READ_LATENCY = 1,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic                   i_fifo_empty,
  input  logic [WIDTH-1:0]       i_fifo_data,
  output logic                   o_fifo_read_request,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic [WIDTH-1:0]       o_out_data,
  output logic                   o_busy,
  output logic [COUNT_WIDTH-1:0] o_xfer_count
);

  localparam int BUF_DEPTH = READ_LATENCY + 1;
  localparam int PTR_W     = $clog2(BUF_DEPTH);
  // One spare bit so occupancy + inflight never overflows.
  localparam int OCC_W     = $clog2(BUF_DEPTH + 1) + 1;
  localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [READ_LATENCY-1:0]  r_inflight;
  logic [WIDTH-1:0]         r_buf [BUF_DEPTH];
  logic [PTR_W-1:0]         r_head;
  logic [PTR_W-1:0]         r_tail;
  logic [OCC_W-1:0]         r_occ;
  logic [COUNT_WIDTH-1:0]   r_xfer_count;

  logic                     w_pop;
  logic                     w_capture;
  logic                     w_read;
  logic [OCC_W-1:0]         w_inflight_cnt;
  logic [READ_LATENCY:0]    w_shift;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Outputs come straight from registers.
  // There is no combinational path from the FIFO data bus to the stream.
  assign o_out_valid         = (r_occ != '0);
  assign o_out_data          = r_buf[r_head];
  assign o_busy              = (r_state != IDLE);
  assign o_xfer_count        = r_xfer_count;
  assign o_fifo_read_request = w_read;

  assign w_pop     = o_out_valid & i_out_ready;
  assign w_capture = r_inflight[READ_LATENCY-1];
  assign w_shift   = {r_inflight, w_read};

  // Number of reads issued whose data has not yet been captured.
  always_comb begin
    w_inflight_cnt = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      w_inflight_cnt = w_inflight_cnt + OCC_W'(r_inflight[i]);
    end
  end

  // Issue a read only when a buffer slot is guaranteed for it.
  // The slot count includes words already buffered and words still in flight.
  // A word popped this cycle frees its slot.
  always_comb begin
    w_read = 1'b0;
    if ((r_state == RUN) && !i_fifo_empty &&
        ((r_occ + w_inflight_cnt - OCC_W'(w_pop)) < DEPTH_C)) begin
      w_read = 1'b1;
    end
  end

  // Next-state logic.
  // STOP gives priority to a returning enable over finishing the drain.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (i_enable) w_state_next = RUN;
      RUN:  if (!i_enable) w_state_next = STOP;
      STOP: begin
        if (i_enable) begin
          w_state_next = RUN;
        end else if ((w_inflight_cnt == '0) && (r_occ == '0)) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register, in-flight tracker and delivered-word counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_inflight   <= '0;
      r_xfer_count <= '0;
    end else begin
      r_state    <= w_state_next;
      r_inflight <= w_shift[READ_LATENCY-1:0];
      if (w_pop) r_xfer_count <= r_xfer_count + 1'b1;
    end
  end

  // Circular prefetch buffer.
  // A capture and a pop in the same cycle leave the occupancy unchanged.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) r_buf[i] <= '0;
    end else begin
      if (w_capture) begin
        r_buf[r_tail] <= i_fifo_data;
        r_tail        <= next_ptr(r_tail);
      end
      if (w_pop) r_head <= next_ptr(r_head);
      case ({w_capture, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_drain.sv
// Testbench for fifo_drain.
// Instance A uses READ_LATENCY=1 and COUNT_WIDTH=16.
// Instance B uses READ_LATENCY=3 and COUNT_WIDTH=4.
// Each instance is fed by a behavioural FIFO with matching read latency.
// Expected words go into per-instance queues when stimulus is issued.
// Monitors pop and compare them whenever a word is accepted downstream.
module tb_fifo_drain;

  logic clk = 1'b0;
  int   cycle = 0;
  int   tests = 0;
  int   fails = 0;

  // Clock generation and a free-running cycle counter for latency checks.
  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  logic        rstA = 1'b1, enA = 1'b0, readyA = 1'b0;
  logic        emptyA = 1'b1;
  logic [3:0]  dataA = '0;
  logic        rdA, validA, busyA;
  logic [3:0]  outA;
  logic [15:0] cntA;

  logic        rstB = 1'b1, enB = 1'b0, readyB = 1'b0;
  logic        emptyB = 1'b1;
  logic [7:0]  pipeB0 = '0, pipeB1 = '0, pipeB2 = '0;
  logic        rdB, validB, busyB;
  logic [7:0]  outB;
  logic [3:0]  cntB;

  logic [3:0] fifoQA[$];
  logic [7:0] fifoQB[$];
  logic [3:0] expA[$];
  logic [7:0] expB[$];

  fifo_drain #(.WIDTH(4), .READ_LATENCY(1), .COUNT_WIDTH(16)) dutA (
    .i_clk(clk), .i_reset(rstA), .i_enable(enA), .i_fifo_empty(emptyA),
    .i_fifo_data(dataA), .o_fifo_read_request(rdA), .o_out_valid(validA),
    .i_out_ready(readyA), .o_out_data(outA), .o_busy(busyA), .o_xfer_count(cntA));

  fifo_drain #(.WIDTH(8), .READ_LATENCY(3), .COUNT_WIDTH(4)) dutB (
    .i_clk(clk), .i_reset(rstB), .i_enable(enB), .i_fifo_empty(emptyB),
    .i_fifo_data(pipeB2), .o_fifo_read_request(rdB), .o_out_valid(validB),
    .i_out_ready(readyB), .o_out_data(outB), .o_busy(busyB), .o_xfer_count(cntB));

  // Behavioural FIFO A: one cycle of read latency.
  // Empty reflects a pop on the same edge.
  always @(posedge clk) begin
    if (rdA && fifoQA.size() > 0) dataA <= fifoQA.pop_front();
    emptyA <= (fifoQA.size() == 0);
  end

  // Behavioural FIFO B: three-stage read data pipeline.
  always @(posedge clk) begin
    if (rdB && fifoQB.size() > 0) pipeB0 <= fifoQB.pop_front();
    else pipeB0 <= '0;
    pipeB1 <= pipeB0;
    pipeB2 <= pipeB1;
    emptyB <= (fifoQB.size() == 0);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic applyStimulus(input int which, input logic en, input logic rdy);
    if (which == 0) begin
      enA    = en;
      readyA = rdy;
    end else begin
      enB    = en;
      readyB = rdy;
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor A.
  // Scores accepted words and tracks read count, rise cycles and violations.
  int         readsA = 0, rdRiseA = 0, valRiseA = 0, rdEmptyViolA = 0, stableViolA = 0;
  logic       prevRdA = 1'b0, prevValA = 1'b0, prevHoldA = 1'b0;
  logic [3:0] prevDataA = '0;
  always @(negedge clk) begin
    if (!rstA) begin
      if (rdA) begin
        readsA++;
        if (emptyA) rdEmptyViolA++;
      end
      if (rdA && !prevRdA) rdRiseA = cycle;
      if (validA && !prevValA) valRiseA = cycle;
      if (prevHoldA && (!validA || outA != prevDataA)) stableViolA++;
      if (validA && readyA) begin
        if (expA.size() == 0) begin
          checkOutput("scoreboardA unexpected word", {28'd0, outA}, 32'hFFFF_FFFF);
        end else begin
          checkOutput("scoreboardA word", {28'd0, outA}, {28'd0, expA.pop_front()});
        end
      end
      prevRdA   = rdA;
      prevValA  = validA;
      prevHoldA = validA && !readyA;
      prevDataA = outA;
    end else begin
      prevHoldA = 1'b0;
      prevRdA   = 1'b0;
      prevValA  = 1'b0;
    end
  end

  // Monitor B.
  // Also tracks the longest run of valid cycles.
  // It also tracks the peak number of words fetched but not yet accepted.
  int         readsB = 0, popsB = 0, rdRiseB = 0, valRiseB = 0, runB = 0, maxRunB = 0;
  int         maxOutB = 0, rdEmptyViolB = 0, stableViolB = 0;
  logic       prevRdB = 1'b0, prevValB = 1'b0, prevHoldB = 1'b0;
  logic [7:0] prevDataB = '0;
  always @(negedge clk) begin
    if (!rstB) begin
      if (rdB) begin
        readsB++;
        if (emptyB) rdEmptyViolB++;
      end
      if (rdB && !prevRdB) rdRiseB = cycle;
      if (validB && !prevValB) valRiseB = cycle;
      if (prevHoldB && (!validB || outB != prevDataB)) stableViolB++;
      if (validB) runB++;
      else runB = 0;
      if (runB > maxRunB) maxRunB = runB;
      if (validB && readyB) begin
        popsB++;
        if (expB.size() == 0) begin
          checkOutput("scoreboardB unexpected word", {24'd0, outB}, 32'hFFFF_FFFF);
        end else begin
          checkOutput("scoreboardB word", {24'd0, outB}, {24'd0, expB.pop_front()});
        end
      end
      if (readsB - popsB > maxOutB) maxOutB = readsB - popsB;
      prevRdB   = rdB;
      prevValB  = validB;
      prevHoldB = validB && !readyB;
      prevDataB = outB;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  int base;

  initial begin
    // Reset state of both instances.
    waitCycles(3);
    @(negedge clk);
    checkOutput("reset validA", {31'd0, validA}, 0);
    checkOutput("reset rdA", {31'd0, rdA}, 0);
    checkOutput("reset busyA", {31'd0, busyA}, 0);
    checkOutput("reset cntA", {16'd0, cntA}, 0);
    checkOutput("reset outA", {28'd0, outA}, 0);
    checkOutput("reset validB", {31'd0, validB}, 0);
    checkOutput("reset cntB", {28'd0, cntB}, 0);
    @(posedge clk); #1;
    rstA = 1'b0;
    rstB = 1'b0;

    // Three words, sink always ready.
    fifoQA.push_back(4'hA); fifoQA.push_back(4'hB); fifoQA.push_back(4'hC);
    expA.push_back(4'hA); expA.push_back(4'hB); expA.push_back(4'hC);
    waitCycles(2);
    base = readsA;
    applyStimulus(0, 1'b1, 1'b1);
    waitCycles(10);
    checkOutput("t1 reads issued", readsA - base, 3);
    checkOutput("t1 read-to-valid latency", valRiseA - rdRiseA, 2);
    checkOutput("t1 xfer_count", {16'd0, cntA}, 3);
    checkOutput("t1 busy after empty", {31'd0, busyA}, 1);
    checkOutput("t1 scoreboard drained", expA.size(), 0);

    // Backpressure: eight words with the sink stalled.
    applyStimulus(0, 1'b1, 1'b0);
    base = readsA;
    for (int i = 0; i < 8; i++) begin
      fifoQA.push_back(4'(i));
      expA.push_back(4'(i));
    end
    waitCycles(10);
    checkOutput("t2 reads under backpressure", readsA - base, 2);
    checkOutput("t2 valid held", {31'd0, validA}, 1);
    checkOutput("t2 head word", {28'd0, outA}, 0);
    waitCycles(3);
    checkOutput("t2 head word stable", {28'd0, outA}, 0);
    applyStimulus(0, 1'b1, 1'b1);
    waitCycles(15);
    checkOutput("t2 scoreboard drained", expA.size(), 0);
    checkOutput("t2 xfer_count", {16'd0, cntA}, 11);
    applyStimulus(0, 1'b0, 1'b1);
    waitCycles(4);
    checkOutput("t2 idle after disable", {31'd0, busyA}, 0);

    // Drop enable with one word buffered and one read in flight.
    for (int i = 1; i <= 4; i++) fifoQA.push_back(4'(i));
    expA.push_back(4'h1); expA.push_back(4'h2);
    waitCycles(2);
    base = readsA;
    applyStimulus(0, 1'b1, 1'b0);
    waitCycles(2);
    applyStimulus(0, 1'b0, 1'b0);
    waitCycles(5);
    checkOutput("t3 no reads after disable", readsA - base, 2);
    checkOutput("t3 busy while draining", {31'd0, busyA}, 1);
    applyStimulus(0, 1'b0, 1'b1);
    waitCycles(5);
    checkOutput("t3 busy after drain", {31'd0, busyA}, 0);
    checkOutput("t3 scoreboard drained", expA.size(), 0);
    checkOutput("t3 xfer_count", {16'd0, cntA}, 13);

    // Reset with two words buffered; those words are lost.
    fifoQA.push_back(4'h5); fifoQA.push_back(4'h6);
    applyStimulus(0, 1'b1, 1'b0);
    waitCycles(6);
    checkOutput("t4 buffered valid", {31'd0, validA}, 1);
    checkOutput("t4 buffered head", {28'd0, outA}, 3);
    rstA = 1'b1;
    applyStimulus(0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("t4 valid after reset", {31'd0, validA}, 0);
    checkOutput("t4 count after reset", {16'd0, cntA}, 0);
    checkOutput("t4 read after reset", {31'd0, rdA}, 0);
    @(posedge clk); #1;
    rstA = 1'b0;
    expA.push_back(4'h5); expA.push_back(4'h6);
    applyStimulus(0, 1'b1, 1'b1);
    waitCycles(10);
    checkOutput("t4 scoreboard drained", expA.size(), 0);
    checkOutput("t4 xfer_count", {16'd0, cntA}, 2);

    // READ_LATENCY=3: ten words, sink always ready.
    for (int i = 0; i < 10; i++) begin
      fifoQB.push_back(8'h10 + 8'(i));
      expB.push_back(8'h10 + 8'(i));
    end
    waitCycles(2);
    applyStimulus(1, 1'b1, 1'b1);
    waitCycles(25);
    checkOutput("t5 read-to-valid latency", valRiseB - rdRiseB, 4);
    checkOutput("t5 consecutive valid cycles", maxRunB, 10);
    checkOutput("t5 outstanding within depth", {31'd0, (maxOutB <= 4)}, 1);
    checkOutput("t5 xfer_count", {28'd0, cntB}, 10);

    // Seven more words give 17 pops, so the 4-bit counter wraps to 1.
    for (int i = 0; i < 7; i++) begin
      fifoQB.push_back(8'h20 + 8'(i));
      expB.push_back(8'h20 + 8'(i));
    end
    waitCycles(20);
    checkOutput("t6 xfer_count wrap", {28'd0, cntB}, 1);
    checkOutput("t6 scoreboard drained", expB.size(), 0);

    checkOutput("read while empty A", rdEmptyViolA, 0);
    checkOutput("read while empty B", rdEmptyViolB, 0);
    checkOutput("output stability A", stableViolA, 0);
    checkOutput("output stability B", stableViolB, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_drain.md
Name: fifo_drain

Overview:
- Read-side master for the team's FIFO: pops words from a FIFO via its read_request/empty/data_out interface and presents them downstream as a valid/ready stream.
- Hides the FIFO memory read latency with a small prefetch buffer, so a continuously ready sink sees one word per cycle.
- Sits between a FIFO instance and any stream consumer (UART TX, packetiser, ...).

Parameters:
- WIDTH, 4, data word width; must match the FIFO WIDTH.
- READ_LATENCY, 1, cycles from read_request asserted to word valid on fifo_data; legal range 1..4.
- COUNT_WIDTH, 16, width of the delivered-word counter.
- Derived, not a port parameter: BUF_DEPTH = READ_LATENCY+1 entries.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = fetch from the FIFO; 0 = stop issuing reads and drain what is in flight.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  WIDTH  FIFO data_out.
- fifo_read_request  out  1  pop strobe to the FIFO, one word per asserted cycle.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  sink accepts the word this cycle.
- out_data  out  WIDTH  head word.
- busy  out  1  state != IDLE.
- xfer_count  out  COUNT_WIDTH  number of words accepted downstream; wraps modulo 2^COUNT_WIDTH.

Behaviour:
- Reset, synchronous and sampled on clk: all outputs are 0 and state=IDLE. The in-flight tracker, buffer occupancy, head/tail pointers and xfer_count are all cleared.
- Reset mid-operation: in-flight words are discarded and lost. This is accepted. The FIFO's own state is not touched.
- pop = out_valid & out_ready. xfer_count increments by 1 on each pop.
- In-flight tracker: READ_LATENCY-stage shift register of valid bits.
  - Stage 0 loads fifo_read_request each cycle.
  - When the last stage is 1, fifo_data is written to the buffer at tail on that edge.
- Buffer: circular, BUF_DEPTH entries, FIFO order.
  - out_data = buf[head]; out_valid = (occupancy != 0).
  - Both are combinational from registers only, with no combinational path from fifo_data.
- Read-issue rule: fifo_read_request = run & !fifo_empty & (occupancy + inflight - pop < BUF_DEPTH).
  - run is 1 only in state RUN.
  - inflight is the count of 1s in the tracker.
  - This guarantees the buffer never overflows.
  - Simultaneous capture and pop in one cycle leaves occupancy unchanged.
- Latency: read issued in cycle t gives fifo_data valid in cycle t+READ_LATENCY, captured at the end of that cycle. out_valid is first high in cycle t+READ_LATENCY+1.
- Throughput: with FIFO non-empty and out_ready held at 1, exactly one word is delivered per cycle in steady state.
- The FIFO must deassert empty or reflect a pop no later than the cycle after the pop; the block never asserts fifo_read_request while fifo_empty=1.
- out_valid/out_data stability: once out_valid=1, out_valid and out_data hold until popped. Reset is the only exception.
- FSM:
  - IDLE: enable=1 -> RUN.
  - RUN: enable=0 -> STOP. Reads are issued per the rule above.
  - STOP: no reads issued. Returns to IDLE when inflight==0 and occupancy==0. If enable returns to 1 first, returns to RUN.
- Empty FIFO in RUN: stay in RUN with no reads and busy=1. busy reflects the enabled state, not whether data is present.
- Wrap-around: head/tail wrap modulo BUF_DEPTH; xfer_count wraps from all-ones to 0.

Test Plan:
- Reset, FIFO with 3 words, enable=1, out_ready=1, READ_LATENCY=1:
  - fifo_read_request high cycles 0-2.
  - out_valid cycles 2-4 with words in FIFO order (A,B,C).
  - xfer_count=3; busy stays 1 after the FIFO empties.
- Backpressure, out_ready=0 from cycle 0 with FIFO holding 8 words:
  - Exactly BUF_DEPTH=2 reads issued, then fifo_read_request stays 0.
  - out_data holds word 0 stable.
  - Releasing out_ready delivers words 0..7 in order with none dropped or duplicated.
- enable dropped while 1 read is in flight and 1 word is buffered:
  - No further reads are issued.
  - Both words are delivered, then busy falls to 0 and state is IDLE.
- Reset asserted with 2 words buffered:
  - Next cycle out_valid=0, xfer_count=0, fifo_read_request=0.
  - After release with enable=1, fetching resumes from the FIFO's current head.
- READ_LATENCY=3, FIFO with 10 words, out_ready=1:
  - First out_valid appears 4 cycles after the first read.
  - 10 consecutive cycles of out_valid follow, and at most 4 words are ever buffered or in flight.
- COUNT_WIDTH=4: after 17 pops, xfer_count=1, confirming wrap.
